// File: rtl/laser_pkg.sv
// Shared types and defaults for the two-circle laser cover search engine.
package laser_pkg;
  typedef enum logic [1:0] {LOAD, PASS1, PASS2, FINISH} state_e;

  localparam int DEF_COORD_W  = 4;
  localparam int DEF_RADIUS   = 4;
  localparam int DEF_NUM_PTS  = 40;
  localparam int DEF_MAX_ITER = 4;

  // Width holding dx^2 + dy^2 without overflow.
  function automatic int sq_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction
endpackage

// File: rtl/laser_cover_search_if.sv
// Point input / result output bundle of the laser cover search engine.
interface laser_cover_search_if import laser_pkg::*; #(
  parameter int COORD_W = DEF_COORD_W
);
  logic [COORD_W-1:0] X, Y;
  logic [COORD_W-1:0] C1X, C1Y, C2X, C2Y;
  logic               DONE;

  modport master (output X, Y, input C1X, C1Y, C2X, C2Y, DONE);
  modport slave  (input X, Y, output C1X, C1Y, C2X, C2Y, DONE);
endinterface

// File: rtl/laser_cover_unit.sv
// Combinational coverage mask: bit i set iff point i lies within RADIUS of (cx,cy).
module laser_cover_unit import laser_pkg::*; #(
  parameter int NUM_PTS = DEF_NUM_PTS,
  parameter int COORD_W = DEF_COORD_W,
  parameter int RADIUS  = DEF_RADIUS
) (
  input  logic [COORD_W-1:0]                 cx,
  input  logic [COORD_W-1:0]                 cy,
  input  logic [NUM_PTS-1:0][2*COORD_W-1:0]  pts,
  output logic [NUM_PTS-1:0]                 mask
);
  localparam int SW = sq_w(COORD_W);
  localparam logic [SW-1:0] R2 = SW'(RADIUS * RADIUS);

  for (genvar i = 0; i < NUM_PTS; i++) begin : g_pt
    logic [COORD_W-1:0] px, py, adx, ady;
    logic [SW-1:0]      dxw, dyw;
    assign px  = pts[i][COORD_W-1:0];
    assign py  = pts[i][2*COORD_W-1:COORD_W];
    assign adx = (px > cx) ? px - cx : cx - px;
    assign ady = (py > cy) ? py - cy : cy - py;
    assign dxw = SW'(adx);
    assign dyw = SW'(ady);
    assign mask[i] = (dxw * dxw + dyw * dyw) <= R2;
  end
endmodule

// File: rtl/laser_cover_search.sv
// Load / alternating-pass search / report engine for two fixed-radius circles.
// Optional LASER_EARLY_EXIT_EN stops once a pass pair no longer grows the union.
module laser_cover_search import laser_pkg::*; #(
  parameter int NUM_PTS  = DEF_NUM_PTS,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int RADIUS   = DEF_RADIUS,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input logic                 CLK,
  input logic                 RST,
  laser_cover_search_if.slave bus
);
  localparam int CW2 = 2 * COORD_W;
  localparam int SCW = $clog2(NUM_PTS + 1);
  localparam int PIW = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
  localparam int ITW = $clog2(MAX_ITER + 1);

  typedef logic [CW2-1:0]     cen_t;
  typedef logic [NUM_PTS-1:0] msk_t;

  state_e                      state_q, state_d;
  logic [PIW-1:0]              pt_idx_q, pt_idx_d;
  logic [NUM_PTS-1:0][CW2-1:0] pts_q, pts_d;
  cen_t                        cand_q, cand_d, best_q, best_d;
  cen_t                        c1_q, c1_d, c2_q, c2_d, c1o_q, c1o_d, c2o_q, c2o_d;
  msk_t                        m1_q, m1_d, m2_q, m2_d, best_m_q, best_m_d;
  logic [SCW-1:0]              best_sc_q, best_sc_d;
  logic [ITW-1:0]              pair_q, pair_d;
  logic                        done_q, done_d;
`ifdef LASER_EARLY_EXIT_EN
  logic [SCW-1:0]              prev_q, prev_d;
`endif

  msk_t           cand_m, fixed_m, sel_m;
  cen_t           sel_c;
  logic [SCW-1:0] score, sel_sc;
  logic           take, fin;

  laser_cover_unit #(.NUM_PTS(NUM_PTS), .COORD_W(COORD_W), .RADIUS(RADIUS)) u_cover (
    .cx  (cand_q[COORD_W-1:0]),
    .cy  (cand_q[CW2-1:COORD_W]),
    .pts (pts_q),
    .mask(cand_m)
  );

  // The other circle's mask is fixed for the whole pass; a cleared mask means "unset".
  assign fixed_m = (state_q == PASS1) ? m2_q : m1_q;

  always_comb begin
    score = '0;
    for (int i = 0; i < NUM_PTS; i++) score = score + SCW'(cand_m[i] | fixed_m[i]);
    take   = (cand_q == '0) || (score > best_sc_q);
    sel_c  = take ? cand_q : best_q;
    sel_sc = take ? score  : best_sc_q;
    sel_m  = take ? cand_m : best_m_q;
  end

  always_comb begin
    state_d   = state_q;
    pt_idx_d  = pt_idx_q;
    pts_d     = pts_q;
    cand_d    = cand_q;
    best_d    = best_q;
    best_sc_d = best_sc_q;
    best_m_d  = best_m_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    c1o_d     = c1o_q;
    c2o_d     = c2o_q;
    pair_d    = pair_q;
    done_d    = 1'b0;
    fin       = 1'b0;
`ifdef LASER_EARLY_EXIT_EN
    prev_d    = prev_q;
`endif
    case (state_q)
      LOAD: begin
        pts_d[pt_idx_q] = {bus.Y, bus.X};
        if (pt_idx_q == PIW'(NUM_PTS - 1)) begin
          pt_idx_d = '0;
          state_d  = PASS1;
        end else begin
          pt_idx_d = pt_idx_q + 1'b1;
        end
      end
      PASS1, PASS2: begin
        cand_d    = cand_q + 1'b1;
        best_d    = sel_c;
        best_sc_d = sel_sc;
        best_m_d  = sel_m;
        if (&cand_q) begin
          if (state_q == PASS1) begin
            c1_d    = sel_c;
            m1_d    = sel_m;
            state_d = PASS2;
          end else begin
            c2_d   = sel_c;
            m2_d   = sel_m;
            pair_d = pair_q + 1'b1;
            fin    = (int'(pair_q) + 1 >= MAX_ITER);
`ifdef LASER_EARLY_EXIT_EN
            if (!fin) begin
              if (sel_sc <= prev_q) fin = 1'b1;
              else                  prev_d = sel_sc;
            end
`endif
            if (fin) begin
              state_d = FINISH;
              c1o_d   = c1_q;
              c2o_d   = sel_c;
              done_d  = 1'b1;
            end else begin
              state_d = PASS1;
            end
          end
        end
      end
      FINISH: begin
        state_d = LOAD;
        pair_d  = '0;
        m1_d    = '0;
        m2_d    = '0;
`ifdef LASER_EARLY_EXIT_EN
        prev_d  = '0;
`endif
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= LOAD;
      pt_idx_q  <= '0;
      pts_q     <= '0;
      cand_q    <= '0;
      best_q    <= '0;
      best_sc_q <= '0;
      best_m_q  <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      m1_q      <= '0;
      m2_q      <= '0;
      c1o_q     <= '0;
      c2o_q     <= '0;
      pair_q    <= '0;
      done_q    <= 1'b0;
`ifdef LASER_EARLY_EXIT_EN
      prev_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pt_idx_q  <= pt_idx_d;
      pts_q     <= pts_d;
      cand_q    <= cand_d;
      best_q    <= best_d;
      best_sc_q <= best_sc_d;
      best_m_q  <= best_m_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      c1o_q     <= c1o_d;
      c2o_q     <= c2o_d;
      pair_q    <= pair_d;
      done_q    <= done_d;
`ifdef LASER_EARLY_EXIT_EN
      prev_q    <= prev_d;
`endif
    end
  end

  assign bus.C1X  = c1o_q[COORD_W-1:0];
  assign bus.C1Y  = c1o_q[CW2-1:COORD_W];
  assign bus.C2X  = c2o_q[COORD_W-1:0];
  assign bus.C2Y  = c2o_q[CW2-1:COORD_W];
  assign bus.DONE = done_q;
endmodule

// File: tb/tb_laser_cover_search.sv
// Directed bench: default engine plus an 8-point 3-bit-grid variant on a shared clock.
module tb_laser_cover_search;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst8 = 1'b1;
  int   cyc = 0, cyc8 = 0, checks = 0, passed = 0;

`ifdef LASER_EARLY_EXIT_EN
  localparam int EXP_DONE  = 1065;
  localparam int EXP_DONE8 = 265;
`else
  localparam int EXP_DONE  = 2089;
  localparam int EXP_DONE8 = 521;
`endif

  always #5 clk = ~clk;

  laser_cover_search_if #(.COORD_W(4)) bus ();
  laser_cover_search_if #(.COORD_W(3)) bus8 ();

  laser_cover_search #(.NUM_PTS(40), .COORD_W(4), .RADIUS(4), .MAX_ITER(4)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
  laser_cover_search #(.NUM_PTS(8), .COORD_W(3), .RADIUS(2), .MAX_ITER(4)) dut8 (
    .CLK(clk), .RST(rst8), .bus(bus8)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Called at a negedge; afterwards cyc = 1 is the first LOAD cycle.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic load_job(input int kind);
    for (int i = 0; i < 40; i++) begin
      case (kind)
        1:       begin bus.X = 4'd5;  bus.Y = 4'd5;  end
        2:       if (i < 20) begin bus.X = 4'd2; bus.Y = 4'd2; end
                 else        begin bus.X = 4'd13; bus.Y = 4'd13; end
        default: begin bus.X = 4'd10; bus.Y = 4'd10; end
      endcase
      tick();
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    while (dc < 0 && cyc < 3000) begin
      if (bus.DONE === 1'b1) dc = cyc;
      else tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    checks++; if (bus.C1X  !== 4'd0) $display("FAIL rst_c1x got %0d exp 0", bus.C1X);  else passed++;
    checks++; if (bus.C1Y  !== 4'd0) $display("FAIL rst_c1y got %0d exp 0", bus.C1Y);  else passed++;
    checks++; if (bus.C2X  !== 4'd0) $display("FAIL rst_c2x got %0d exp 0", bus.C2X);  else passed++;
    checks++; if (bus.C2Y  !== 4'd0) $display("FAIL rst_c2y got %0d exp 0", bus.C2Y);  else passed++;
    checks++; if (bus.DONE !== 1'b0) $display("FAIL rst_done got %0b exp 0", bus.DONE); else passed++;
  endtask

  task automatic test_single_cluster();
    int dc;
    do_reset();
    load_job(1);
    wait_done(dc);
    checks++; if (dc !== EXP_DONE) $display("FAIL s1_done_cycle got %0d exp %0d", dc, EXP_DONE); else passed++;
    checks++; if (bus.C1X !== 4'd5) $display("FAIL s1_c1x got %0d exp 5", bus.C1X); else passed++;
    checks++; if (bus.C1Y !== 4'd1) $display("FAIL s1_c1y got %0d exp 1", bus.C1Y); else passed++;
    checks++; if (bus.C2X !== 4'd0) $display("FAIL s1_c2x got %0d exp 0", bus.C2X); else passed++;
    checks++; if (bus.C2Y !== 4'd0) $display("FAIL s1_c2y got %0d exp 0", bus.C2Y); else passed++;
    tick();
    checks++; if (bus.DONE !== 1'b0) $display("FAIL s1_done_pulse got %0b exp 0", bus.DONE); else passed++;
  endtask

  task automatic test_two_clusters();
    int dc;
    do_reset();
    load_job(2);
    wait_done(dc);
    checks++; if (dc !== EXP_DONE) $display("FAIL s2_done_cycle got %0d exp %0d", dc, EXP_DONE); else passed++;
    checks++; if (bus.C1X !== 4'd0)  $display("FAIL s2_c1x got %0d exp 0", bus.C1X);  else passed++;
    checks++; if (bus.C1Y !== 4'd0)  $display("FAIL s2_c1y got %0d exp 0", bus.C1Y);  else passed++;
    checks++; if (bus.C2X !== 4'd13) $display("FAIL s2_c2x got %0d exp 13", bus.C2X); else passed++;
    checks++; if (bus.C2Y !== 4'd9)  $display("FAIL s2_c2y got %0d exp 9", bus.C2Y);  else passed++;
    tick();
    checks++; if (bus.DONE !== 1'b0) $display("FAIL s2_done_pulse got %0b exp 0", bus.DONE); else passed++;
    checks++; if (bus.C2Y !== 4'd9)  $display("FAIL s2_hold_c2y got %0d exp 9", bus.C2Y); else passed++;
  endtask

  // Entered in the first LOAD cycle after the previous DONE; outputs still hold (0,0)/(13,9).
  task automatic test_reset_mid();
    int dc;
    bit spurious = 1'b0;
    cyc = 1;
    load_job(2);
    repeat (300) begin
      if (bus.DONE === 1'b1) spurious = 1'b1;
      tick();
    end
    do_reset();
    checks++; if (bus.C1X  !== 4'd0) $display("FAIL mid_c1x got %0d exp 0", bus.C1X);  else passed++;
    checks++; if (bus.C1Y  !== 4'd0) $display("FAIL mid_c1y got %0d exp 0", bus.C1Y);  else passed++;
    checks++; if (bus.C2X  !== 4'd0) $display("FAIL mid_c2x got %0d exp 0", bus.C2X);  else passed++;
    checks++; if (bus.C2Y  !== 4'd0) $display("FAIL mid_c2y got %0d exp 0", bus.C2Y);  else passed++;
    checks++; if (bus.DONE !== 1'b0) $display("FAIL mid_done got %0b exp 0", bus.DONE); else passed++;
    checks++; if (spurious !== 1'b0) $display("FAIL mid_no_done got %0b exp 0", spurious); else passed++;
    load_job(2);
    wait_done(dc);
    checks++; if (dc !== EXP_DONE)   $display("FAIL mid_done_cycle got %0d exp %0d", dc, EXP_DONE); else passed++;
    checks++; if (bus.C1X !== 4'd0)  $display("FAIL mid_r_c1x got %0d exp 0", bus.C1X);  else passed++;
    checks++; if (bus.C1Y !== 4'd0)  $display("FAIL mid_r_c1y got %0d exp 0", bus.C1Y);  else passed++;
    checks++; if (bus.C2X !== 4'd13) $display("FAIL mid_r_c2x got %0d exp 13", bus.C2X); else passed++;
    checks++; if (bus.C2Y !== 4'd9)  $display("FAIL mid_r_c2y got %0d exp 9", bus.C2Y);  else passed++;
  endtask

  // Entered on job A's DONE cycle; job B streams from the very next cycle.
  task automatic test_back_to_back();
    int dc = -1;
    bit held = 1'b1;
    tick();
    cyc = 1;
    load_job(3);
    while (dc < 0 && cyc < 3000) begin
      if (bus.DONE === 1'b1) dc = cyc;
      else begin
        if (bus.C1X !== 4'd0 || bus.C1Y !== 4'd0 || bus.C2X !== 4'd13 || bus.C2Y !== 4'd9) held = 1'b0;
        tick();
      end
    end
    checks++; if (held !== 1'b1)     $display("FAIL b2b_hold got %0b exp 1", held); else passed++;
    checks++; if (dc !== EXP_DONE)   $display("FAIL b2b_done_cycle got %0d exp %0d", dc, EXP_DONE); else passed++;
    checks++; if (bus.C1X !== 4'd10) $display("FAIL b2b_c1x got %0d exp 10", bus.C1X); else passed++;
    checks++; if (bus.C1Y !== 4'd6)  $display("FAIL b2b_c1y got %0d exp 6", bus.C1Y);  else passed++;
    checks++; if (bus.C2X !== 4'd0)  $display("FAIL b2b_c2x got %0d exp 0", bus.C2X);  else passed++;
    checks++; if (bus.C2Y !== 4'd0)  $display("FAIL b2b_c2y got %0d exp 0", bus.C2Y);  else passed++;
  endtask

  task automatic test_param_variant();
    int dc = -1;
    bus8.X = 3'd7;
    bus8.Y = 3'd7;
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    cyc8 = 1;
    while (dc < 0 && cyc8 < 1000) begin
      if (bus8.DONE === 1'b1) dc = cyc8;
      else begin @(negedge clk); cyc8++; end
    end
    checks++; if (dc !== EXP_DONE8)   $display("FAIL p8_done_cycle got %0d exp %0d", dc, EXP_DONE8); else passed++;
    checks++; if (bus8.C1X !== 3'd7)  $display("FAIL p8_c1x got %0d exp 7", bus8.C1X); else passed++;
    checks++; if (bus8.C1Y !== 3'd5)  $display("FAIL p8_c1y got %0d exp 5", bus8.C1Y); else passed++;
    checks++; if (bus8.C2X !== 3'd0)  $display("FAIL p8_c2x got %0d exp 0", bus8.C2X); else passed++;
    checks++; if (bus8.C2Y !== 3'd0)  $display("FAIL p8_c2y got %0d exp 0", bus8.C2Y); else passed++;
  endtask

  initial begin
    bus.X  = '0;
    bus.Y  = '0;
    bus8.X = '0;
    bus8.Y = '0;
    test_reset();
    test_single_cluster();
    test_two_clusters();
    test_reset_mid();
    test_back_to_back();
    test_param_variant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
